music_ctrl: RTL
===============

# music_ctrl

Top-level controller for the music player. It turns user button pulses (play/pause, next) and the end-of-song indication from the note-sequencing path into the player's `play` enable, a one-cycle `reset_play` restart strobe, and the current song index. It sits above the song reader and note player, which run only while `play` is high and restart their address/note state on `reset_play`.

## Interface
Parameters:
- SONG_NUM, 4, number of stored songs; index wraps from SONG_NUM-1 to 0 (2 ≤ SONG_NUM ≤ 2^SONG_W)
- SONG_W, 2, width of the song index
- AUTO_NEXT, 1, 1: end of song advances to the next song and keeps playing; 0: end of song stops and rewinds the same song

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
- play_pause  in  1  one-cycle pulse, toggles play/pause (already debounced and edge-detected upstream)
- next  in  1  one-cycle pulse, skip to next song
- song_done  in  1  level/pulse from song reader: current song has ended
- play  out  1  high while playing
- reset_play  out  1  one-cycle restart strobe to song reader / note player
- song  out  SONG_W  current song index

## Operation
- Moore FSM, 2-bit state register: RESET, PAUSE, PLAY, NEXT. Outputs decoded from the state register only; `song` and `resume` flag are separate registers.
- Reset (reset=0, any time, including mid-song): state=RESET, song=0, resume=0. Outputs during and immediately after reset: play=0, reset_play=1 (RESET state), song=0.
- RESET: play=0, reset_play=1. Unconditionally → PAUSE next edge. Inputs ignored.
- PAUSE: play=0, reset_play=0. Priority: next → NEXT with resume=0; else play_pause → PLAY; else stay. song_done ignored.
- PLAY: play=1, reset_play=0. Priority next > song_done > play_pause:
  - next → NEXT, resume=1.
  - song_done, AUTO_NEXT=1 → NEXT, resume=1.
  - song_done, AUTO_NEXT=0 → RESET (stop, song unchanged, rewind).
  - play_pause → PAUSE (song position retained in downstream; no reset_play).
- NEXT: play=0, reset_play=1. → PLAY if resume=1, else → PAUSE. Inputs ignored; resume cleared on exit.
- Song index: incremented on the same edge the FSM enters NEXT; SONG_NUM-1 → 0 wrap (not a power-of-two mask when SONG_NUM < 2^SONG_W). Unchanged in all other transitions. Never returns to 0 except via reset or wrap.
- Unused/illegal encodings → RESET next edge.

## Timing
- Input pulse sampled at edge E → state change visible after E; outputs update in the cycle after E (1-cycle latency, no combinational path input→output).
- next pulse at edge E: cycle after E: state NEXT, song already new value, reset_play=1, play=0; after E+1: PLAY (if was playing) with play=1, or PAUSE.
- reset_play is exactly one cycle wide per NEXT entry and for the first cycle after reset release; back-to-back next pulses during NEXT are dropped.
- Reset release: RESET for one cycle, then PAUSE; play never asserts without a play_pause pulse.
- play_pause and next in the same cycle: next wins; play_pause lost.
- song_done held high in PAUSE has no effect; when PLAY is next entered with song_done still high, it is acted on in that first PLAY cycle.

## Test plan
- Reset: drive reset=0 mid-PLAY with song=2 → play=0, song=0 immediately; after release one cycle reset_play=1, then PAUSE, play=0.
- Play/pause: pulse play_pause → next cycle play=1; pulse again → play=0, reset_play never asserted, song unchanged.
- Next while playing, SONG_NUM=4: from song=3 pulse next → one cycle reset_play=1, play=0, song=0; following cycle play=1.
- Next while paused: pulse next in PAUSE, song=1 → song=2, reset_play one cycle, returns to PAUSE with play=0.
- End of song: AUTO_NEXT=1, song=0, assert song_done in PLAY → song=1, reset_play pulse, play resumes; AUTO_NEXT=0 → song stays 0, RESET then PAUSE, play=0.
- Simultaneous/odd: next+play_pause same cycle in PAUSE → NEXT then PAUSE; SONG_NUM=3 wrap 2→0; next pulse during NEXT ignored (song advances once).

Source files
------------

// File: rtl/music_ctrl.sv
// music_ctrl: play/pause/next control for the music player.
// Converts button pulses and the end-of-song indication into the play
// enable, a one-cycle restart strobe, and the current song index.
module music_ctrl #(
  parameter int unsigned SONG_NUM  = 4,
  parameter int unsigned SONG_W    = 2,
  parameter bit          AUTO_NEXT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_pause,
  input  logic              next,
  input  logic              song_done,
  output logic              play,
  output logic              reset_play,
  output logic [SONG_W-1:0] song
);

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_PAUSE = 2'b01,
    S_PLAY  = 2'b10,
    S_NEXT  = 2'b11
  } state_t;

  localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(SONG_NUM - 1);

  state_t state;
  logic   resume;
  logic   enter_next;

  // Detect the transitions that move the FSM into NEXT this edge
  always_comb begin
    enter_next = 1'b0;
    case (state)
      S_PAUSE: enter_next = next;
      S_PLAY:  enter_next = next || (song_done && AUTO_NEXT);
      default: enter_next = 1'b0;
    endcase
  end

  // Main control FSM and resume flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_RESET;
      resume <= 1'b0;
    end else begin
      case (state)
        S_RESET: state <= S_PAUSE;
        S_PAUSE: begin
          if (next) begin
            state  <= S_NEXT;
            resume <= 1'b0;
          end else if (play_pause) begin
            state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (next || (song_done && AUTO_NEXT)) begin
            state  <= S_NEXT;
            resume <= 1'b1;
          end else if (song_done) begin
            state <= S_RESET;
          end else if (play_pause) begin
            state <= S_PAUSE;
          end
        end
        S_NEXT: begin
          state  <= resume ? S_PLAY : S_PAUSE;
          resume <= 1'b0;
        end
        default: state <= S_RESET;
      endcase
    end
  end

  // Song index advances on entry to NEXT, wrapping at SONG_NUM-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      song <= '0;
    end else if (enter_next) begin
      song <= (song == SONG_LAST) ? '0 : song + 1'b1;
    end
  end

  // Outputs decoded from the state register only
  always_comb begin
    play       = (state == S_PLAY);
    reset_play = (state == S_RESET) || (state == S_NEXT);
  end

endmodule
